instr_prefetch_buffer: RTL and testbench
========================================

# instr_prefetch_buffer

Parametrised instruction prefetch buffer with a compressed-instruction aligner, sitting between the instruction memory port and the decode stage. Keeps up to `MAX_OUTSTANDING` word requests in flight on a req/gnt/rvalid bus, buffers returned words in a `DEPTH`-entry FIFO, and presents one aligned 16- or 32-bit instruction per handshake with its PC. Supports redirect (flush) to any halfword address, dropping responses still in flight, and tags bus errors per instruction.

## Interface
- `PC_RESET`, 32'h0, fetch address after reset (halfword aligned).
- `DEPTH`, 3, FIFO word entries (≥2).
- `MAX_OUTSTANDING`, 2, max granted-but-unanswered requests (1..DEPTH).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_o  out  1  bus request.
- addr_o  out  32  word address, bits [1:0]=0.
- gnt_i  in  1  request accepted this cycle.
- rvalid_i  in  1  response valid (one per grant, in order).
- rdata_i  in  32  response word.
- err_i  in  1  response error, qualified by rvalid_i.
- flush_i  in  1  redirect; discard all buffered and in-flight data.
- flush_pc_i  in  32  redirect target, bit 0 ignored.
- out_valid_o  out  1  instruction available.
- out_ready_i  in  1  consumer accepts.
- out_instr_o  out  32  instruction; compressed ones zero-extended in [31:16].
- out_pc_o  out  32  PC of out_instr_o.
- out_compressed_o  out  1  instruction is 16-bit (low bits != 2'b11).
- out_err_o  out  1  any word covering the instruction returned err_i.

## Operation
- Issue: `req_o`=1 when `outstanding < MAX_OUTSTANDING` and `outstanding + occupied < DEPTH`. `addr_o` and `req_o` held stable until `gnt_i`; `fetch_addr += 4` on grant.
- Response: on `rvalid_i`, if `discard_cnt > 0`, decrement it and drop the word; otherwise push {rdata, err} at the FIFO tail. `outstanding` decrements on every `rvalid_i`.
- Aligner: `pc[1]`=0 uses entry0 [15:0]/[31:0]; `pc[1]`=1 uses entry0 [31:16], plus entry1 [15:0] if 32-bit. `out_valid_o` requires every covering word present. err = OR of covering words' err.
- Pop on `out_valid_o & out_ready_i`: pc += 2 or 4; entry0 dropped when the instruction ends at or beyond its upper halfword.
- Flush: FIFO cleared, `discard_cnt <= outstanding - rvalid_i + (req_o & gnt_i)`, `pc <= {flush_pc_i[31:1],0}`, `fetch_addr <= {flush_pc_i[31:2],00}`. If `req_o` is high without `gnt_i`, request stays asserted with the old address until granted; that response is discarded. Flush takes priority over pop and push in the same cycle.
- Errors do not stop fetching; the consumer redirects.
- Counters saturate-free by construction: `outstanding` ≤ `MAX_OUTSTANDING`, `discard_cnt` ≤ `MAX_OUTSTANDING`; widths `$clog2(MAX_OUTSTANDING+1)`.

## Timing
- Reset values: `req_o`=0, `addr_o`=`PC_RESET & ~3`, `out_valid_o`=0, `out_pc_o`=`PC_RESET`, `out_instr_o`=0, `out_compressed_o`=0, `out_err_o`=0, all counters 0, FIFO empty.
- First `req_o` in the first cycle after `rstn` deasserts.
- Latency: grant at cycle N, `rvalid_i` at N+1 → `out_valid_o` at N+2 (registered FIFO, no bypass).
- Outputs are a function of registered state only. `out_valid_o` never depends on `out_ready_i`.
- Push and pop in the same cycle on a full FIFO are legal: the pop frees a slot before the push.
- `rvalid_i` with `outstanding`=0 is a protocol violation (assertion).
- Reset mid-burst clears everything; late responses after reset are not the block's concern.

## Structure
- `fetch_pkg`: `fetch_entry_t` {logic [31:0] data; logic err;}, function `is_compressed(logic [1:0])`, `INSTR_W`=32.
- Sub-module `fetch_fifo` (DEPTH entries, push/pop/clear, exposes entry0/entry1 and occupancy); aligner, counters and request logic live in the top level.

## Test plan
- Reset, gnt_i=1 always, rvalid one cycle later, memory words 0x00000013 sequential from 0 → out_pc 0,4,8,… one per cycle, `out_compressed_o`=0.
- Word 0x00A10505 at 0x0 (two compressed) then 0x00000013 → pcs 0x0, 0x2, 0x4; instrs 0x0505, 0x00A1, 0x00000013.
- 32-bit 0x12345677 straddling, flush to 0x102: word 0x100 = 0x5677xxxx, word 0x104 = 0xxxxx1234 → out_instr 0x12345677, pc 0x102 only after both words arrive.
- Flush with 2 outstanding → both late responses dropped; the first output is from the new target.
- Hold `out_ready_i`=0 → `req_o` stops once outstanding + occupied = DEPTH; no overflow. Release → order preserved.
- `err_i` on the second half of a straddling 32-bit instruction → `out_err_o`=1 on that instruction only.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction prefetch buffer.
package fetch_pkg;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic               err;
  } fetch_entry_t;
  function automatic logic is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular word FIFO exposing the two oldest entries to the aligner.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [INSTR_W:0] push_data_i,
  output logic [INSTR_W:0] entry0_o,
  output logic [16:0]      entry1_o,
  output logic [CW-1:0]    count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q, rd_nxt;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign rd_nxt   = inc(rd_q);
  assign entry0_o = mem_q[rd_q];
  assign entry1_o = {mem_q[rd_nxt].data[15:0], mem_q[rd_nxt].err};
  assign count_o  = cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= pop_i ? rd_nxt : rd_q;
      wr_q  <= push_i ? inc(wr_q) : wr_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  // A pop and push on a full FIFO reuse the slot just vacated by the pop.
  always_ff @(posedge clk)
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: pipelined word fetcher with FIFO and 16/32-bit aligner,
// supporting redirects that drop in-flight responses.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int          DEPTH           = 3,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_err_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_addr_q, fetch_addr_d, pc_q, pc_d, stale_addr_q, stale_addr_d;
  logic [OW-1:0] outst_q, outst_d, disc_q, disc_d;
  logic          stale_q, stale_d, run_q;
  logic [CW-1:0] occ;
  fetch_entry_t  e0;
  logic [15:0]   e1_lo, lo;
  logic          e1_err, hi, comp, grant, fire, push, pop;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .clear_i(flush_i), .push_i(push), .pop_i(pop),
    .push_data_i({rdata_i, err_i}), .entry0_o(e0), .entry1_o({e1_lo, e1_err}),
    .count_o(occ)
  );

  assign hi               = pc_q[1];
  assign lo               = hi ? e0.data[31:16] : e0.data[15:0];
  assign comp             = is_compressed(lo[1:0]);
  assign out_valid_o      = occ != '0 && (comp || !hi || occ > CW'(1));
  assign out_instr_o      = !out_valid_o ? '0 : comp ? {16'h0, lo} : hi ? {e1_lo, lo} : e0.data;
  assign out_compressed_o = out_valid_o & comp;
  assign out_err_o        = out_valid_o & (e0.err | (hi & ~comp & e1_err));
  assign out_pc_o         = pc_q;
  // A request caught by a redirect before its grant stays on the bus with its old address.
  assign req_o  = run_q & (stale_q | (32'(outst_q) < MAX_OUTSTANDING && 32'(outst_q) + 32'(occ) < DEPTH));
  assign addr_o = stale_q ? stale_addr_q : fetch_addr_q;
  assign grant  = req_o & gnt_i;
  assign fire   = out_valid_o & out_ready_i & ~flush_i;
  assign pop    = fire & (hi | ~comp);
  assign push   = rvalid_i & disc_q == '0 & ~flush_i;

  always_comb begin
    outst_d      = outst_q + OW'(grant) - OW'(rvalid_i);
    disc_d       = flush_i ? outst_d : disc_q - OW'(rvalid_i && disc_q != '0) + OW'(grant && stale_q);
    stale_d      = req_o & ~gnt_i & (flush_i | stale_q);
    stale_addr_d = stale_q ? stale_addr_q : fetch_addr_q;
    fetch_addr_d = flush_i ? flush_pc_i & ~32'd3 : fetch_addr_q + (grant && !stale_q ? 32'd4 : 32'd0);
    pc_d         = flush_i ? flush_pc_i & ~32'd1 : pc_q + (fire ? (comp ? 32'd2 : 32'd4) : 32'd0);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      run_q        <= 1'b0;
      fetch_addr_q <= PC_RESET & ~32'd3;
      pc_q         <= PC_RESET;
      stale_addr_q <= '0;
      stale_q      <= 1'b0;
      outst_q      <= '0;
      disc_q       <= '0;
    end else begin
      run_q        <= 1'b1;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      stale_q      <= stale_d;
      outst_q      <= outst_d;
      disc_q       <= disc_d;
    end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rstn) !(rvalid_i && outst_q == '0));
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed vector table plus hand sequences for redirect,
// straddling, backpressure and stalled-request corner cases.
module tb_instr_prefetch_buffer;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_o, gnt_i = 1'b1, rvalid_i = 1'b0, err_i = 1'b0;
  logic [31:0] addr_o, rdata_i = '0;
  logic        flush_i = 1'b0, out_valid_o, out_ready_i = 1'b0, out_compressed_o, out_err_o;
  logic [31:0] flush_pc_i = '0, out_instr_o, out_pc_o;

  instr_prefetch_buffer #(.PC_RESET(32'h0), .DEPTH(3), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rstn(rstn), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_compressed_o(out_compressed_o),
    .out_err_o(out_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] mem [logic [31:0]];
  bit          errm [logic [31:0]];
  logic [31:0] pend [$];
  logic        resp_en = 1'b1, slow = 1'b0, seen100 = 1'b0, seen104 = 1'b0;
  int          n600 = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  // Bus model: grants sampled mid-cycle, answered in order one cycle later unless held back.
  initial begin
    logic        g;
    logic [31:0] a, ra;
    int          cyc = 0;
    forever begin
      @(negedge clk);
      g = req_o && gnt_i && rstn;
      a = addr_o;
      @(posedge clk);
      #1;
      cyc++;
      if (!rstn) pend.delete();
      else if (g) begin
        pend.push_back(a);
        if (a[31:8] == 24'h6) n600++;
      end
      if (rstn && resp_en && pend.size() > 0 && (!slow || cyc % 4 == 0)) begin
        ra = pend.pop_front();
        rvalid_i = 1'b1;
        rdata_i = rd(ra);
        err_i = errm.exists(ra);
        if (ra == 32'h100) seen100 = 1'b1;
        if (ra == 32'h104) seen104 = 1'b1;
      end else begin
        rvalid_i = 1'b0;
        rdata_i = '0;
        err_i = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush_i = 1'b1;
    flush_pc_i = pc;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic expect_instr(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                              input logic c, input logic e, output int w);
    out_ready_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!out_valid_o && w < 60) begin
      @(negedge clk);
      w++;
    end
    check({nm, " valid"}, 32'(out_valid_o), 32'd1);
    check({nm, " pc"}, out_pc_o, pc);
    check({nm, " instr"}, out_instr_o, ins);
    check({nm, " compressed"}, 32'(out_compressed_o), 32'(c));
    check({nm, " err"}, 32'(out_err_o), 32'(e));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        flush;
    logic [31:0] fpc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        err;
    logic        imm;
  } vec_t;

  function automatic vec_t v(input logic f, input logic [31:0] fpc, input logic [31:0] pc,
                             input logic [31:0] ins, input logic c, input logic e, input logic imm);
    vec_t r;
    r.flush = f; r.fpc = fpc; r.pc = pc; r.instr = ins; r.comp = c; r.err = e; r.imm = imm;
    return r;
  endfunction

  initial begin
    vec_t        vt [$];
    int          w;
    logic [31:0] old;
    vt.push_back(v(0, 0, 32'h0, 32'h13, 0, 0, 0));
    for (int i = 1; i < 6; i++) vt.push_back(v(0, 0, 32'(4 * i), 32'h13, 0, 0, 1));
    vt.push_back(v(1, 32'h0, 32'h0, 32'h0505, 1, 0, 0));
    vt.push_back(v(0, 0, 32'h2, 32'h00A1, 1, 0, 0));
    vt.push_back(v(0, 0, 32'h4, 32'h13, 0, 0, 0));
    vt.push_back(v(1, 32'h200, 32'h200, 32'h0001, 1, 0, 0));
    vt.push_back(v(0, 0, 32'h202, 32'h12345677, 0, 1, 0));
    vt.push_back(v(0, 0, 32'h206, 32'h0001, 1, 1, 0));
    vt.push_back(v(0, 0, 32'h208, 32'h13, 0, 0, 0));
    mem[32'h100] = 32'h5677_0001; mem[32'h104] = 32'h0001_1234;
    mem[32'h200] = 32'h5677_0001; mem[32'h204] = 32'h0001_1234; errm[32'h204] = 1'b1;
    mem[32'h300] = 32'h3333_3313; mem[32'h304] = 32'h3333_3393;
    mem[32'h400] = 32'h0040_0093; mem[32'h500] = 32'h0050_0093;
    for (int i = 0; i < 8; i++) mem[32'h600 + 32'(4 * i)] = 32'h13 | (32'(i) << 20);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req", 32'(req_o), 0);
    check("reset addr", addr_o, 0);
    check("reset valid", 32'(out_valid_o), 0);
    check("reset pc", out_pc_o, 0);
    check("reset instr", out_instr_o, 0);
    check("reset compressed", 32'(out_compressed_o), 0);
    check("reset err", 32'(out_err_o), 0);
    rstn = 1'b1;

    w = 0;
    @(negedge clk);
    while (!req_o && w < 5) begin
      @(negedge clk);
      w++;
    end
    check("first req", 32'(req_o), 1);
    check("first addr", addr_o, 0);
    @(negedge clk);
    check("latency valid N+1", 32'(out_valid_o), 0);
    @(negedge clk);
    check("latency valid N+2", 32'(out_valid_o), 1);
    @(posedge clk);
    #1;
    mem[32'h0] = 32'h00A1_0505;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].flush) do_flush(vt[i].fpc);
      expect_instr($sformatf("vec%0d", i), vt[i].pc, vt[i].instr, vt[i].comp, vt[i].err, w);
      if (vt[i].imm) check($sformatf("vec%0d back-to-back wait", i), 32'(w), 0);
    end

    seen100 = 1'b0; seen104 = 1'b0; slow = 1'b1;
    do_flush(32'h102);
    w = 0;
    @(negedge clk);
    while (!out_valid_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("straddle valid", 32'(out_valid_o), 1);
    check("straddle both words returned", 32'(seen104), 1);
    check("straddle pc", out_pc_o, 32'h102);
    check("straddle instr", out_instr_o, 32'h12345677);
    check("straddle compressed", 32'(out_compressed_o), 0);
    @(posedge clk);
    #1;
    slow = 1'b0;
    expect_instr("after straddle", 32'h106, 32'h0001, 1, 0, w);
    expect_instr("after straddle 2", 32'h108, 32'h13, 0, 0, w);

    out_ready_i = 1'b0;
    n600 = 0;
    do_flush(32'h600);
    repeat (12) @(posedge clk);
    #1;
    @(negedge clk);
    check("backpressure req stops", 32'(req_o), 0);
    check("backpressure grants", 32'(n600), 3);
    check("backpressure valid", 32'(out_valid_o), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      expect_instr($sformatf("release%0d", i), 32'h600 + 32'(4 * i), 32'h13 | (32'(i) << 20), 0, 0, w);

    gnt_i = 1'b0;
    w = 0;
    @(negedge clk);
    while (!req_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("stall req pending", 32'(req_o), 1);
    old = addr_o;
    @(posedge clk);
    #1;
    do_flush(32'h500);
    @(negedge clk);
    check("stall req held", 32'(req_o), 1);
    check("stall addr held", addr_o, old);
    @(posedge clk);
    #1;
    gnt_i = 1'b1;
    expect_instr("after stalled flush", 32'h500, 32'h0050_0093, 0, 0, w);

    resp_en = 1'b0;
    out_ready_i = 1'b0;
    do_flush(32'h300);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("outstanding cap req", 32'(req_o), 0);
    check("nothing returned", 32'(out_valid_o), 0);
    @(posedge clk);
    #1;
    do_flush(32'h400);
    resp_en = 1'b1;
    expect_instr("flush drop 0", 32'h400, 32'h0040_0093, 0, 0, w);
    expect_instr("flush drop 1", 32'h404, 32'h13, 0, 0, w);

    rstn = 1'b0;
    #1;
    check("midburst reset req", 32'(req_o), 0);
    check("midburst reset valid", 32'(out_valid_o), 0);
    check("midburst reset pc", out_pc_o, 0);
    check("midburst reset addr", addr_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
